div_unit: RTL and testbench

Iterative 32-bit integer divider in the execute stage of the out-of-order core. It consumes `OPGEN_DIV` / `OPGEN_DIVU` operations emitted by the ID-stage opcode generator, after the operands and ROB tag are attached by issue. It returns quotient (LO) and remainder (HI) with the tag to the HI/LO write-back path. It computes one quotient bit per cycle via restoring division and handles exactly one operation at a time under valid/ready handshakes.

---
 rtl/div_unit_pkg.sv | 30 +++
 rtl/div_unit_if.sv | 30 +++
 rtl/div_unit_step.sv | 24 ++
 rtl/div_unit.sv | 98 +++++++++
 tb/tb_div_unit.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared opcode constants, divider state encoding and a
// magnitude helper for the iterative divider.
//   OPGEN_*      : opcode values from the ID-stage generator (only DIV/DIVU used)
//   opgen_bus_t  : width of the opcode bus
//   DIV_CYCLES   : number of restoring steps per operation
//   div_state_t  : DIV_IDLE / DIV_CALC / DIV_DONE
package div_unit_pkg;

  localparam int OPGEN_W = 6;
  typedef logic [OPGEN_W-1:0] opgen_bus_t;

  localparam opgen_bus_t OPGEN_ADD  = 6'h01;
  localparam opgen_bus_t OPGEN_DIV  = 6'h1a;
  localparam opgen_bus_t OPGEN_DIVU = 6'h1b;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Two's-complement negate when neg is set. 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: issue-side request and write-back-side response of the divider.
//   master : issue / write-back (drives request, out_ready)
//   slave  : div_unit (drives in_ready and the result)
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int TAG_WIDTH = 5
) ();
  logic                 in_valid;
  logic                 in_ready;
  opgen_bus_t           opgen;
  logic [31:0]          operand_1;
  logic [31:0]          operand_2;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_hi;
  logic [31:0]          out_lo;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, opgen, operand_1, operand_2, in_tag, out_ready,
    input  in_ready, out_valid, out_hi, out_lo, out_tag
  );

  modport slave (
    input  in_valid, opgen, operand_1, operand_2, in_tag, out_ready,
    output in_ready, out_valid, out_hi, out_lo, out_tag
  );
endinterface

// File: rtl/div_unit_step.sv
// div_step: one combinational restoring-division step.
//   rem, quo, divisor -> rem_nxt, quo_nxt
// {rem,quo} shifts left by one; if the shifted remainder (33 bits) is at
// least the divisor it is reduced and a 1 enters the quotient.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_nxt,
  output logic [31:0] quo_nxt
);
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] sub_lo;

  assign shifted = {rem, quo[31]};
  assign ge      = shifted >= {1'b0, divisor};
  // When ge holds the true difference is below divisor, so it fits in
  // 32 bits and equals the low-half subtraction.
  assign sub_lo  = shifted[31:0] - divisor;

  assign rem_nxt = ge ? sub_lo : shifted[31:0];
  assign quo_nxt = {quo[30:0], ge};
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit restoring divider (DIV / DIVU), one quotient
// bit per cycle, one operation in flight.
//   clk   : core clock
//   rst   : synchronous active-low reset
//   flush : kills any in-flight operation
//   bus   : request (in_valid/in_ready, opgen, operands, tag) and
//           response (out_valid/out_ready, out_hi = remainder,
//           out_lo = quotient, out_tag)
module div_unit
  import div_unit_pkg::*;
#(
  parameter int TAG_WIDTH = 5
) (
  input logic       clk,
  input logic       rst,
  input logic       flush,
  div_unit_if.slave bus
);
  div_state_t           state_q, state_d;
  logic [5:0]           cnt_q;
  logic [31:0]          rem_q, quo_q, dvsr_q;
  logic                 s1_q, s2_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [31:0]          rem_nxt, quo_nxt;

  logic is_div, is_signed, div_zero, accept, s1_in, s2_in;

  assign is_signed = bus.opgen == OPGEN_DIV;
  assign is_div    = is_signed || (bus.opgen == OPGEN_DIVU);
  assign div_zero  = bus.operand_2 == '0;
  assign accept    = (state_q == DIV_IDLE) && bus.in_valid && is_div && !flush;
  assign s1_in     = is_signed & bus.operand_1[31];
  assign s2_in     = is_signed & bus.operand_2[31];

  div_step u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvsr_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= DIV_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (accept) state_d = div_zero ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt_q == 6'(DIV_CYCLES - 1)) state_d = DIV_DONE;
      DIV_DONE: if (bus.out_ready) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (flush) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      tag_q  <= '0;
    end else if (accept) begin
      tag_q <= bus.in_tag;
      cnt_q <= '0;
      if (div_zero) begin
        // Raw dividend and all-ones quotient; clearing the signs makes the
        // output fix-up a pass-through.
        rem_q  <= bus.operand_1;
        quo_q  <= '1;
        dvsr_q <= '0;
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
      end else begin
        rem_q  <= '0;
        quo_q  <= mag(bus.operand_1, s1_in);
        dvsr_q <= mag(bus.operand_2, s2_in);
        s1_q   <= s1_in;
        s2_q   <= s2_in;
      end
    end else if (state_q == DIV_CALC) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q + 6'd1;
    end
  end

  assign bus.in_ready  = state_q == DIV_IDLE;
  assign bus.out_valid = state_q == DIV_DONE;
  assign bus.out_lo    = mag(quo_q, s1_q ^ s2_q);
  assign bus.out_hi    = mag(rem_q, s1_q);
  assign bus.out_tag   = tag_q;
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  div_unit_if #(.TAG_WIDTH(TW)) bus ();

  div_unit #(.TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   hi;
    logic [31:0]   lo;
    logic [TW-1:0] tag;
    int            acc;
    int            lat;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_bp = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic (truncating signed division).
  function automatic exp_t model(input opgen_bus_t op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [TW-1:0] tag);
    exp_t   e;
    longint sa, sd, q, r;
    e.tag = tag;
    e.acc = 0;
    e.lat = 33;
    if (b == 0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.lat = 1;
    end else if (op == OPGEN_DIVU) begin
      e.lo = a / b;
      e.hi = a % b;
    end else begin
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      q  = sa / sd;
      r  = sa % sd;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end
    return e;
  endfunction

  // Monitor: latency, hold-stability under backpressure, and result compare.
  bit            hold = 0;
  bit            lat_done = 0;
  logic [31:0]   ph, pl;
  logic [TW-1:0] pt;
  exp_t          me;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected 0");
      end else begin
        if (!lat_done) begin
          chk("latency", 32'(cyc - scb[0].acc), 32'(scb[0].lat));
          lat_done = 1;
        end
        if (hold) begin
          chk("hold_hi", bus.out_hi, ph);
          chk("hold_lo", bus.out_lo, pl);
          chk("hold_tag", 32'(bus.out_tag), 32'(pt));
        end
        if (bus.out_ready) begin
          me = scb.pop_front();
          chk("result_hi", bus.out_hi, me.hi);
          chk("result_lo", bus.out_lo, me.lo);
          chk("result_tag", 32'(bus.out_tag), 32'(me.tag));
          hold = 0;
          lat_done = 0;
        end else begin
          hold = 1;
          ph = bus.out_hi;
          pl = bus.out_lo;
          pt = bus.out_tag;
        end
      end
    end else begin
      hold = 0;
    end
  end

  // Random backpressure, changed just after the edge to stay clear of the monitor.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1 bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input opgen_bus_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TW-1:0] tag, input bit exp_out);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.opgen     = op;
    bus.operand_1 = a;
    bus.operand_2 = b;
    bus.in_tag    = tag;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("issue_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    e = model(op, a, b, tag);
    e.acc = cyc;
    @(posedge clk);
    if (exp_out) scb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (scb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(scb.size()), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    opgen_bus_t op;
    int         n;
    bus.in_valid  = 1'b0;
    bus.opgen     = OPGEN_ADD;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_hi", bus.out_hi, 32'd0);
    chk("rst_out_lo", bus.out_lo, 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    rst = 1'b1;

    // Directed operations
    issue(OPGEN_DIVU, 32'd100, 32'd7, 5'd3, 1);
    issue(OPGEN_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 1);
    issue(OPGEN_DIV, 32'd7, 32'hFFFF_FFFE, 5'd5, 1);
    issue(OPGEN_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd6, 1);
    issue(OPGEN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1);
    issue(OPGEN_DIV, 32'd5, 32'd0, 5'd8, 1);
    drain();

    // Non-divide opcode: never accepted
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.opgen     = OPGEN_ADD;
    bus.operand_1 = 32'd10;
    bus.operand_2 = 32'd3;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("nondiv_in_ready", 32'(bus.in_ready), 32'd1);
    end
    bus.in_valid = 1'b0;

    // Backpressure in DONE then release and a back-to-back op
    bus.out_ready = 1'b0;
    issue(OPGEN_DIVU, 32'd1000, 32'd33, 5'd9, 1);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (10) @(negedge clk);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    issue(OPGEN_DIV, 32'hFFFF_FC18, 32'd33, 5'd10, 1);
    drain();

    // Flush in CALC cycle 15
    issue(OPGEN_DIVU, 32'd12345, 32'd7, 5'd11, 0);
    repeat (14) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (40) @(negedge clk);

    // Reset mid-CALC, then DIVU 9 / 3
    issue(OPGEN_DIV, 32'hFFFF_0000, 32'd77, 5'd12, 0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_hi", bus.out_hi, 32'd0);
    chk("midrst_out_lo", bus.out_lo, 32'd0);
    chk("midrst_out_tag", 32'(bus.out_tag), 32'd0);
    issue(OPGEN_DIVU, 32'd9, 32'd3, 5'd13, 1);
    drain();

    // Randomized operations with random backpressure
    rand_bp = 1;
    for (int i = 0; i < 40; i++) begin
      n = int'($urandom_range(0, 9));
      op = (n == 0) ? OPGEN_ADD : (n[0] ? OPGEN_DIV : OPGEN_DIVU);
      issue(op, pick(), pick(), TW'($urandom), op != OPGEN_ADD);
    end
    drain();
    rand_bp = 0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
